// File: rtl/weight_az_pkg.sv
`default_nettype none
// ============================================================================
// weight_az_pkg : shared sizes, saturation limits and FSM encodings for Weight_Az
// Revision: 1.0
// ============================================================================
package weight_az_pkg;

  localparam int M      = 10;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  localparam logic [31:0] MAX32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_RD_G  = 3'd1;
  localparam logic [2:0] c_LAT_G = 3'd2;
  localparam logic [2:0] c_RD_A  = 3'd3;
  localparam logic [2:0] c_LAT_A = 3'd4;
  localparam logic [2:0] c_WR    = 3'd5;
  localparam logic [2:0] c_DONE  = 3'd6;

  // Clamp a 33-bit signed sum back into the 32-bit range.
  function automatic logic [31:0] sat32(input logic [32:0] i_sum);
    if (i_sum[32] != i_sum[31]) begin
      sat32 = i_sum[32] ? MIN32 : MAX32;
    end else begin
      sat32 = i_sum[31:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_az_mac.sv
`default_nettype none
// ============================================================================
// weight_az_mac : combinational rnd(L_mult(x, y)) with saturation flag
// Revision: 1.0
// ============================================================================
module weight_az_mac
  import weight_az_pkg::*;
(
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_y,
  output logic        [15:0] o_res,
  output logic               o_sat
);

  logic signed [31:0] w_prod;
  logic               w_mult_sat;
  logic        [31:0] w_lmult;
  logic        [32:0] w_sum;
  logic               w_add_sat;
  logic        [31:0] w_rnd;
  logic        [15:0] w_unused_lsb;

  assign w_prod       = i_x * i_y;
  // Only -1 * -1 doubles past the positive limit.
  assign w_mult_sat   = (w_prod == 32'sh4000_0000);
  assign w_lmult      = w_mult_sat ? MAX32 : {w_prod[30:0], 1'b0};
  assign w_sum        = {w_lmult[31], w_lmult} + 33'h0_0000_8000;
  assign w_add_sat    = (w_sum[32] != w_sum[31]);
  assign w_rnd        = sat32(w_sum);
  assign o_res        = w_rnd[31:16];
  assign w_unused_lsb = w_rnd[15:0];
  assign o_sat        = w_mult_sat | w_add_sat;

endmodule
`default_nettype wire

// File: rtl/weight_az_top.sv
`default_nettype none
// ============================================================================
// weight_az_top : Weight_Az FSM, scratch memory and host access muxes.
// Optional sticky ovf output with WEIGHT_AZ_OVF_FLAG_EN.   Revision: 1.0
// ============================================================================
module weight_az_top
  import weight_az_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] AP,
  input  logic [ADDR_W-1:0] gammaAddr,
  input  logic [ADDR_W-1:0] wazReadRequested,
  input  logic [ADDR_W-1:0] wazWriteRequested,
  input  logic [DATA_W-1:0] wazOut,
  input  logic              wazWrite,
  input  logic              wazMuxSel,
  input  logic              wazMux1Sel,
  input  logic              wazMux2Sel,
  input  logic              wazMux3Sel,
  output logic [DATA_W-1:0] readIn
`ifdef WEIGHT_AZ_OVF_FLAG_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [3:0] c_M = 4'(M);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_state;
  logic [3:0]        r_i;
  logic [15:0]       r_fac;
  logic [15:0]       r_gamma;
  logic [15:0]       r_a;
  logic              r_done;

  logic [ADDR_W-1:0] w_fsm_raddr;
  logic [ADDR_W-1:0] w_fsm_waddr;
  logic [DATA_W-1:0] w_fsm_wdata;
  logic              w_fsm_we;
  logic [ADDR_W-1:0] w_raddr;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic [15:0]       w_ap_res;
  logic [15:0]       w_fac_res;
  logic [15:0]       w_ap;
  logic              w_sat_ap;
  logic              w_sat_fac;
  logic              w_upd_fac;
  logic              w_start_ok;

  weight_az_mac u_mac_ap (
    .i_x   (r_a),
    .i_y   (r_fac),
    .o_res (w_ap_res),
    .o_sat (w_sat_ap)
  );

  weight_az_mac u_mac_fac (
    .i_x   (r_gamma),
    .i_y   (r_fac),
    .o_res (w_fac_res),
    .o_sat (w_sat_fac)
  );

  // ap[0] is a plain copy; fac only advances between the first and last terms.
  assign w_ap        = (r_i == 4'd0) ? r_a : w_ap_res;
  assign w_upd_fac   = (r_i != 4'd0) && (r_i < c_M);
  assign w_start_ok  = start && ((r_state == c_IDLE) || (r_state == c_DONE));

  assign w_fsm_raddr = (r_state == c_RD_G) ? gammaAddr : (A + ADDR_W'(r_i));
  assign w_fsm_waddr = AP + ADDR_W'(r_i);
  assign w_fsm_wdata = {{(DATA_W-16){1'b0}}, w_ap};
  assign w_fsm_we    = (r_state == c_WR);

  assign w_raddr = wazMuxSel  ? w_fsm_raddr : wazReadRequested;
  assign w_waddr = wazMux1Sel ? w_fsm_waddr : wazWriteRequested;
  assign w_wdata = wazMux2Sel ? w_fsm_wdata : wazOut;
  assign w_we    = wazMux3Sel ? w_fsm_we    : wazWrite;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_rdata <= r_mem[w_raddr];
  end

  assign readIn = r_rdata;
  assign done   = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_i     <= 4'd0;
      r_fac   <= 16'd0;
      r_gamma <= 16'd0;
      r_a     <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (w_start_ok) begin
            r_state <= c_RD_G;
            r_i     <= 4'd0;
            r_done  <= 1'b0;
          end
        end
        c_RD_G:  r_state <= c_LAT_G;
        c_LAT_G: begin
          r_gamma <= r_rdata[15:0];
          r_fac   <= r_rdata[15:0];
          r_state <= c_RD_A;
        end
        c_RD_A:  r_state <= c_LAT_A;
        c_LAT_A: begin
          r_a     <= r_rdata[15:0];
          r_state <= c_WR;
        end
        c_WR: begin
          if (w_upd_fac) begin
            r_fac <= w_fac_res;
          end
          if (r_i < c_M) begin
            r_i     <= r_i + 4'd1;
            r_state <= c_RD_A;
          end else begin
            r_done  <= 1'b1;
            r_state <= c_DONE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_AZ_OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_start_ok) begin
      r_ovf <= 1'b0;
    end else if (r_state == c_WR) begin
      if (((r_i != 4'd0) && w_sat_ap) || (w_upd_fac && w_sat_fac)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat_ap | w_sat_fac;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_az_top.sv
`default_nettype none
// Self-checking bench for weight_az_top: host-loaded frames, queued expected ap[] values.
`timescale 1ns/1ps
module tb_weight_az_top;
  import weight_az_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic [11:0] A, AP, gammaAddr;
  logic [11:0] wazReadRequested, wazWriteRequested;
  logic [31:0] wazOut;
  logic        wazWrite;
  logic        sel;
  logic [31:0] readIn;
`ifdef WEIGHT_AZ_OVF_FLAG_EN
  logic        ovf;
`endif

  weight_az_top dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .done              (done),
    .A                 (A),
    .AP                (AP),
    .gammaAddr         (gammaAddr),
    .wazReadRequested  (wazReadRequested),
    .wazWriteRequested (wazWriteRequested),
    .wazOut            (wazOut),
    .wazWrite          (wazWrite),
    .wazMuxSel         (sel),
    .wazMux1Sel        (sel),
    .wazMux2Sel        (sel),
    .wazMux3Sel        (sel),
    .readIn            (readIn)
`ifdef WEIGHT_AZ_OVF_FLAG_EN
    ,
    .ovf               (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] q_exp[$];
  logic [15:0] t_a[0:10];
  logic [15:0] t_gamma;
  logic [15:0] got[0:10];
  bit          m_sat;
  bit          exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ITU basic operators, written over wide signed integers.
  function automatic logic [31:0] m_lmult(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y)) * 2;
    if (p > 64'sh7FFF_FFFF) begin
      m_sat = 1'b1;
      p = 64'sh7FFF_FFFF;
    end
    return p[31:0];
  endfunction

  function automatic logic [15:0] m_rnd(input logic [31:0] l);
    longint      s;
    logic [31:0] t;
    s = longint'($signed(l)) + 64'sd32768;
    if (s > 64'sh7FFF_FFFF) begin
      m_sat = 1'b1;
      s = 64'sh7FFF_FFFF;
    end
    t = s[31:0];
    return t[31:16];
  endfunction

  task automatic model_push();
    logic [15:0] fac;
    m_sat = 1'b0;
    q_exp.push_back(t_a[0]);
    fac = t_gamma;
    for (int i = 1; i < M; i++) begin
      q_exp.push_back(m_rnd(m_lmult(t_a[i], fac)));
      fac = m_rnd(m_lmult(t_gamma, fac));
    end
    q_exp.push_back(m_rnd(m_lmult(t_a[M], fac)));
    exp_ovf = m_sat;
  endtask

  // Host load with random junk in the upper half-word, which the FSM must ignore.
  task automatic load_frame(input bit push);
    logic [31:0] r;
    sel = 1'b0;
    @(negedge clk);
    r = $urandom();
    wazWriteRequested = gammaAddr;
    wazOut = {r[31:16], t_gamma};
    wazWrite = 1'b1;
    for (int i = 0; i <= M; i++) begin
      @(negedge clk);
      r = $urandom();
      wazWriteRequested = A + 12'(i);
      wazOut = {r[31:16], t_a[i]};
    end
    @(negedge clk);
    wazWrite = 1'b0;
    if (push) model_push();
  endtask

  task automatic kick();
    @(negedge clk);
    sel = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_clr", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency_ok", {31'd0, (n <= 4*(M+1)+4)}, 32'd1);
`ifdef WEIGHT_AZ_OVF_FLAG_EN
    chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
  endtask

  task automatic read_check(input string tag);
    logic [31:0] d;
    logic [15:0] e;
    @(negedge clk);
    sel = 1'b0;
    for (int i = 0; i <= M; i++) begin
      @(negedge clk);
      wazReadRequested = AP + 12'(i);
      @(negedge clk);
      d = readIn;
      got[i] = d[15:0];
      if (q_exp.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = q_exp.pop_front();
        chk(tag, d, {16'h0000, e});
      end
    end
  endtask

  task automatic frame(input string tag);
    load_frame(1'b1);
    kick();
    wait_done();
    read_check(tag);
  endtask

  initial begin
    int n;
    logic [31:0] r;
    reset = 1'b1; start = 1'b0; sel = 1'b0; wazWrite = 1'b0;
    wazOut = '0; wazReadRequested = '0; wazWriteRequested = '0;
    A = 12'd16; AP = 12'd256; gammaAddr = 12'd1024;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
`ifdef WEIGHT_AZ_OVF_FLAG_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", {29'd0, dut.r_state}, {29'd0, c_IDLE});

    // Hand-computed small case.
    t_gamma = 16'h6000;
    for (int i = 0; i <= M; i++) t_a[i] = 16'h0000;
    t_a[0] = 16'h1000; t_a[1] = 16'h2000; t_a[2] = 16'h2000;
    frame("t1_ap");
    chk("t1_ap0", {16'h0, got[0]}, 32'h1000);
    chk("t1_ap1", {16'h0, got[1]}, 32'h1800);
    chk("t1_ap2", {16'h0, got[2]}, 32'h1200);
    chk("t1_ap3", {16'h0, got[3]}, 32'h0000);

    // Full-scale positive values.
    t_gamma = 16'h7FFF;
    for (int i = 0; i <= M; i++) t_a[i] = 16'h7FFF;
    frame("t2_ap");
    chk("t2_ap0", {16'h0, got[0]}, 32'h7FFF);
    chk("t2_ap1", {16'h0, got[1]}, 32'h7FFE);

    // -1 * -1 saturation.
    t_gamma = 16'h8000;
    for (int i = 0; i <= M; i++) t_a[i] = 16'h0000;
    t_a[1] = 16'h8000;
    frame("t3_ap");
    chk("t3_ap1", {16'h0, got[1]}, 32'h7FFF);

    // Abort in the WR step of i=5, then a full restart of the same frame.
    t_gamma = 16'h5A5A;
    for (int i = 0; i <= M; i++) begin r = $urandom(); t_a[i] = r[15:0]; end
    A = 12'd40; AP = 12'd600; gammaAddr = 12'd3000;
    load_frame(1'b0);
    kick();
    n = 0;
    while (!(dut.r_state == c_WR && dut.r_i == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", {31'd0, (n < 100)}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_state", {29'd0, dut.r_state}, {29'd0, c_IDLE});
    @(negedge clk);
    reset = 1'b0;
    model_push();
    kick();
    wait_done();
    read_check("t5_ap");

    // Back-to-back random frames with moving buffers.
    for (int f = 0; f < 60; f++) begin
      r = $urandom();
      t_gamma = r[15:0];
      for (int i = 0; i <= M; i++) begin r = $urandom(); t_a[i] = r[15:0]; end
      A         = 12'($urandom_range(0, 1000));
      AP        = 12'($urandom_range(1100, 2000));
      gammaAddr = 12'($urandom_range(2100, 4095));
      frame("t6_ap");
    end

    chk("sb_drained", q_exp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
